// File: rtl/mem_load_unit_pkg.sv
// Shared load-op codes, FSM state encoding and alignment helpers for the MEM-stage load unit.
package mem_load_unit_pkg;

  localparam logic [2:0] LDOP_LW  = 3'd0;
  localparam logic [2:0] LDOP_LH  = 3'd1;
  localparam logic [2:0] LDOP_LHU = 3'd2;
  localparam logic [2:0] LDOP_LB  = 3'd3;
  localparam logic [2:0] LDOP_LBU = 3'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  // Codes 5-7 are unused by the decoder and fold onto LW.
  function automatic logic [2:0] norm_op(input logic [2:0] op);
    return (op > LDOP_LBU) ? LDOP_LW : op;
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] off);
    logic mis;
    case (norm_op(op))
      LDOP_LH, LDOP_LHU: mis = off[0];
      LDOP_LB, LDOP_LBU: mis = 1'b0;
      default:           mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_load_unit_if.sv
// Data-memory read port between the load unit (master) and memory (slave).
// mem_req rises with a stable word address and holds, with mem_addr unchanged, until the
// cycle mem_ack is high; mem_rdata is valid only in that cycle and the master drops
// mem_req on the following edge. A request may be abandoned only by reset.
interface mem_load_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/mem_load_unit_load_ext.sv
// Lane select and sign/zero extension of a returned little-endian word.
module load_ext
  import mem_load_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];

    case (op)
      LDOP_LH:  data = {{16{half_sel[15]}}, half_sel};
      LDOP_LHU: data = {16'h0000, half_sel};
      LDOP_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      LDOP_LBU: data = {24'h000000, byte_sel};
      default:  data = word;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// MEM-stage load unit: word read over req/ack, lane extract + extend, stall, AdEL and bus timeout.
module mem_load_unit
  import mem_load_unit_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ld_valid,
  input  logic [2:0]          ld_op,
  input  logic [31:0]         addr,
  input  logic [4:0]          ld_rd,
  input  logic                flush,
  mem_load_unit_if.master     mem,
  output logic                stall,
  output logic                wb_valid,
  output logic [4:0]          wb_rd,
  output logic [31:0]         wb_data,
  output logic                adel,
  output logic                bus_err,
  output logic [31:0]         badvaddr,
  output state_e              dbg_state
);

  localparam logic             TO_EN    = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [1:0]        off_q, off_d;
  logic [4:0]        rd_q, rd_d;
  logic              kill_q, kill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic [31:0]       maddr_q, maddr_d;
  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              adel_q, adel_d;
  logic              bus_err_q, bus_err_d;
  logic [31:0]       badvaddr_q, badvaddr_d;

  logic [31:0]       ext_data;
  logic              ld_mis, accept, ld_adel, timeout_hit;

  load_ext u_load_ext (
    .op     (op_q),
    .offset (off_q),
    .word   (mem.mem_rdata),
    .data   (ext_data)
  );

  assign ld_mis      = misaligned(ld_op, addr[1:0]);
  assign accept      = (state_q == ST_IDLE) && ld_valid && !flush && !ld_mis;
  assign ld_adel     = (state_q == ST_IDLE) && ld_valid && !flush && ld_mis;
  // A late ack in the final allowed cycle still completes the load.
  assign timeout_hit = TO_EN && (state_q == ST_REQ) && (cnt_q == CNT_LAST) && !mem.mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= LDOP_LW;
      off_q      <= 2'b00;
      rd_q       <= 5'd0;
      kill_q     <= 1'b0;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      maddr_q    <= 32'h0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'h0;
      adel_q     <= 1'b0;
      bus_err_q  <= 1'b0;
      badvaddr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      off_q      <= off_d;
      rd_q       <= rd_d;
      kill_q     <= kill_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      maddr_q    <= maddr_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      adel_q     <= adel_d;
      bus_err_q  <= bus_err_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_REQ;
      ST_REQ:  if (mem.mem_ack || timeout_hit) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op_d       = op_q;
    off_d      = off_q;
    rd_d       = rd_q;
    kill_d     = kill_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    maddr_d    = maddr_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    adel_d     = 1'b0;
    bus_err_d  = 1'b0;
    badvaddr_d = badvaddr_q;

    case (state_q)
      ST_IDLE: begin
        kill_d = 1'b0;
        if (accept) begin
          op_d    = norm_op(ld_op);
          off_d   = addr[1:0];
          rd_d    = ld_rd;
          cnt_d   = '0;
          req_d   = 1'b1;
          maddr_d = {addr[31:2], 2'b00};
        end
        if (ld_adel) begin
          adel_d     = 1'b1;
          badvaddr_d = addr;
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (flush) kill_d = 1'b1;
        if (mem.mem_ack) begin
          req_d  = 1'b0;
          kill_d = 1'b0;
          // A flush arriving together with the ack still suppresses write-back.
          if (!(kill_q || flush)) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = ext_data;
          end
        end else if (timeout_hit) begin
          req_d      = 1'b0;
          kill_d     = 1'b0;
          bus_err_d  = 1'b1;
          badvaddr_d = maddr_q;
        end
      end
      default: begin
        req_d  = 1'b0;
        kill_d = 1'b0;
      end
    endcase
  end

  assign stall        = accept || (state_q == ST_REQ);
  assign mem.mem_req  = req_q;
  assign mem.mem_addr = maddr_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign adel         = adel_q;
  assign bus_err      = bus_err_q;
  assign badvaddr     = badvaddr_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_load_unit.sv
// Directed bench for mem_load_unit: scoreboard queues for write-backs and faults, checked by a monitor.
module tb_mem_load_unit;
  import mem_load_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_valid, flush;
  logic [2:0]  ld_op;
  logic [31:0] addr;
  logic [4:0]  ld_rd;
  logic        stall, wb_valid, adel, bus_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, badvaddr;
  state_e      dbg_state;

  mem_load_unit_if mem_bus ();

  mem_load_unit #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_valid  (ld_valid),
    .ld_op     (ld_op),
    .addr      (addr),
    .ld_rd     (ld_rd),
    .flush     (flush),
    .mem       (mem_bus),
    .stall     (stall),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .adel      (adel),
    .bus_err   (bus_err),
    .badvaddr  (badvaddr),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];
  logic [33:0] flt_q[$];
  localparam logic [1:0] K_ADEL = 2'b01;
  localparam logic [1:0] K_BERR = 2'b10;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin : monitor
    logic [36:0] e;
    logic [33:0] f;
    if (rst_n) begin
      if (wb_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_unexpected: got rd %0d data %h expected no write-back", wb_rd, wb_data);
        end else begin
          e = exp_q.pop_front();
          check("wb_rd", 32'(wb_rd), 32'(e[36:32]));
          check("wb_data", wb_data, e[31:0]);
        end
      end
      if (adel === 1'b1 || bus_err === 1'b1) begin
        if (flt_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL fault_unexpected: got adel %b bus_err %b expected no fault", adel, bus_err);
        end else begin
          f = flt_q.pop_front();
          check("fault_kind", 32'({bus_err, adel}), 32'(f[33:32]));
          check("badvaddr", badvaddr, f[31:0]);
        end
      end
    end
  end

  // driver tasks: each starts and ends 1 time unit after a rising edge
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load(input logic [2:0] op, input logic [31:0] a, input logic [4:0] rd,
                      input int dly, input logic [31:0] rdata, input logic [31:0] exp_data,
                      input logic do_flush);
    if (!do_flush) exp_q.push_back({rd, exp_data});
    ld_valid = 1'b1; ld_op = op; addr = a; ld_rd = rd;
    @(negedge clk); check("stall_accept", 32'(stall), 32'd1);
    @(posedge clk); #1; ld_valid = 1'b0;
    for (int i = 0; i <= dly; i++) begin
      if (do_flush && i == 0) flush = 1'b1;
      @(negedge clk);
      check("mem_req_held", 32'(mem_bus.mem_req), 32'd1);
      check("mem_addr", mem_bus.mem_addr, {a[31:2], 2'b00});
      check("stall_req", 32'(stall), 32'd1);
      if (i == dly) begin mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = rdata; end
      @(posedge clk); #1;
      flush = 1'b0; mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = $urandom();
    end
    check("wb_valid_latency", 32'(wb_valid), do_flush ? 32'd0 : 32'd1);
    check("mem_req_drop", 32'(mem_bus.mem_req), 32'd0);
    check("stall_wb_cycle", 32'(stall), 32'd0);
  endtask

  task automatic mis(input logic [2:0] op, input logic [31:0] a);
    flt_q.push_back({K_ADEL, a});
    ld_valid = 1'b1; ld_op = op; addr = a; ld_rd = 5'd9;
    @(negedge clk); check("stall_mis", 32'(stall), 32'd0);
    @(posedge clk); #1; ld_valid = 1'b0;
    check("adel_pulse", 32'(adel), 32'd1);
    check("mis_no_req", 32'(mem_bus.mem_req), 32'd0);
    @(posedge clk); #1;
    check("adel_clear", 32'(adel), 32'd0);
    check("mis_no_req2", 32'(mem_bus.mem_req), 32'd0);
  endtask

  task automatic timeout_load(input logic [31:0] a);
    flt_q.push_back({K_BERR, {a[31:2], 2'b00}});
    ld_valid = 1'b1; ld_op = LDOP_LW; addr = a; ld_rd = 5'd12;
    @(posedge clk); #1; ld_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check("to_req_held", 32'(mem_bus.mem_req), 32'd1);
      @(posedge clk); #1;
    end
    check("bus_err_pulse", 32'(bus_err), 32'd1);
    check("to_req_drop", 32'(mem_bus.mem_req), 32'd0);
    check("to_no_wb", 32'(wb_valid), 32'd0);
    check("to_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1;
    check("bus_err_clear", 32'(bus_err), 32'd0);
  endtask

  task automatic reset_mid_req(input logic [31:0] a);
    ld_valid = 1'b1; ld_op = LDOP_LW; addr = a; ld_rd = 5'd13;
    @(posedge clk); #1; ld_valid = 1'b0;
    #2;
    check("pre_rst_req", 32'(mem_bus.mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mem_req", 32'(mem_bus.mem_req), 32'd0);
    check("rst_mem_addr", mem_bus.mem_addr, 32'h0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_badvaddr", badvaddr, 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_req", 32'(mem_bus.mem_req), 32'd0);
    check("post_rst_wb", 32'(wb_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ld_valid = 1'b0; ld_op = LDOP_LW; addr = 32'h0; ld_rd = 5'd0; flush = 1'b0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'h0;
    #2;
    check("reset_mem_req", 32'(mem_bus.mem_req), 32'd0);
    check("reset_mem_addr", mem_bus.mem_addr, 32'h0);
    check("reset_wb_valid", 32'(wb_valid), 32'd0);
    check("reset_wb_rd", 32'(wb_rd), 32'd0);
    check("reset_wb_data", wb_data, 32'h0);
    check("reset_adel", 32'(adel), 32'd0);
    check("reset_bus_err", 32'(bus_err), 32'd0);
    check("reset_badvaddr", badvaddr, 32'h0);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    idle(1);

    load(LDOP_LB,  32'h0000_1003, 5'd1, 0, 32'h8012_3456, 32'hFFFF_FF80, 1'b0); idle(1);
    load(LDOP_LBU, 32'h0000_1003, 5'd2, 0, 32'h8012_3456, 32'h0000_0080, 1'b0); idle(1);
    load(LDOP_LH,  32'h0000_1002, 5'd3, 1, 32'h8001_ABCD, 32'hFFFF_8001, 1'b0);
    load(LDOP_LHU, 32'h0000_1002, 5'd4, 0, 32'h8001_ABCD, 32'h0000_8001, 1'b0);
    load(LDOP_LH,  32'h0000_1000, 5'd5, 2, 32'h8001_ABCD, 32'hFFFF_ABCD, 1'b0); idle(1);
    load(LDOP_LB,  32'h0000_1001, 5'd6, 0, 32'h8012_3456, 32'h0000_0034, 1'b0); idle(1);

    mis(LDOP_LW, 32'h0000_1002);
    mis(LDOP_LH, 32'h0000_1001);
    mis(3'd7,    32'h0000_3001);
    check("badvaddr_hold", badvaddr, 32'h0000_3001);

    load(LDOP_LW, 32'h0000_2000, 5'd7, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    load(3'd6,    32'h0000_3004, 5'd8, 0, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0); idle(1);

    load(LDOP_LW,  32'h0000_5000, 5'd10, 2, 32'h1111_1111, 32'h0, 1'b1);
    check("flush_wb_data_hold", wb_data, 32'h1357_9BDF);
    load(LDOP_LBU, 32'h0000_5002, 5'd11, 0, 32'hA5B6_C7D8, 32'h0000_00B6, 1'b0); idle(1);

    timeout_load(32'h0000_6004); idle(1);

    reset_mid_req(32'h0000_4000);
    load(LDOP_LHU, 32'h0000_7002, 5'd14, 1, 32'hF00D_0001, 32'h0000_F00D, 1'b0);
    idle(3);

    checks++;
    if (exp_q.size() != 0 || flt_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: got %0d wb and %0d faults pending expected 0", exp_q.size(), flt_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_load_unit.md
Name: mem_load_unit

Overview:
- Read-side companion to the immediate extender, placed in the MEM stage of the pipelined MIPS core.
- Issues word reads to data memory over a req/ack handshake.
- Selects the addressed byte or halfword from the returned word, then sign- or zero-extends it to 32 bits for write-back.
- Stalls the pipeline while a read is outstanding, and flags misaligned loads (AdEL) and bus timeouts.

Parameters:
- TIMEOUT, 255, max cycles mem_req may stay high without mem_ack before bus_err; 0 disables the timeout.
- CNT_W, 8, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ld_valid  in  1  load present in MEM this cycle.
- ld_op  in  3  load type (LDOP_* codes).
- addr  in  32  effective byte address.
- ld_rd  in  5  destination register.
- flush  in  1  kill the in-flight load's write-back.
- mem_req  out  1  read request, held until ack.
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- mem_ack  in  1  read data valid this cycle.
- mem_rdata  in  32  returned word, little-endian lanes.
- stall  out  1  freeze upstream pipeline.
- wb_valid  out  1  one-cycle pulse, result valid.
- wb_rd  out  5  destination register of the result.
- wb_data  out  32  extended load result.
- adel  out  1  one-cycle misaligned-load pulse.
- bus_err  out  1  one-cycle timeout pulse.
- badvaddr  out  32  faulting address, held until next fault.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - mem_req, wb_valid, adel, bus_err = 0.
  - mem_addr, wb_rd, wb_data, badvaddr, timeout counter = 0.
- Misalignment check:
  - LW misaligned when addr[1:0]!=0.
  - LH/LHU misaligned when addr[0]!=0.
  - LB/LBU never misaligned.
- Reserved ld_op codes (5-7) behave as LW.
- IDLE, on ld_valid & !flush & aligned:
  - Next edge: state=REQ, mem_req=1, mem_addr set.
  - Latch op, addr[1:0] and ld_rd; clear the counter.
- IDLE, on ld_valid & !flush & misaligned:
  - Next edge: adel=1 for one cycle, badvaddr=addr.
  - No mem_req; state stays IDLE.
- IDLE, on ld_valid & flush: ignored.
- REQ:
  - mem_req and mem_addr held stable; counter increments each cycle.
  - On mem_ack: mem_req=0 next edge and state=IDLE.
  - On the same ack edge: wb_valid=1 for one cycle, wb_data=extracted value, wb_rd=latched rd.
- Flush while in REQ:
  - Sets a kill flag; the memory read still completes.
  - On ack, wb_valid stays 0.
  - Kill flag clears on return to IDLE.
- Timeout (TIMEOUT>0):
  - When counter==TIMEOUT-1 and no ack: bus_err=1 for one cycle, badvaddr=mem_addr, mem_req=0, state=IDLE, no wb_valid.
  - If ack arrives in that same cycle, ack wins.
- stall (combinational) = (IDLE & ld_valid & !flush & aligned) | REQ.
  - stall is 0 in the cycle wb_valid is high.
  - A new load is accepted in that cycle (back-to-back).
- Latency: ld_valid at T, earliest mem_req at T+1, ack at T+1 gives wb_valid at T+2. Each cycle of ack delay adds 1.
- Byte lanes: byte k = rdata[8k+7:8k]; halfword at offset 0 = rdata[15:0], at offset 2 = rdata[31:16].
- Extension:
  - LB/LH: sign-extend from bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: full word.
- wb_data holds its value between pulses.
- Reset asserted mid-REQ:
  - Immediate return to IDLE; mem_req drops asynchronously.
  - No wb_valid; memory must tolerate the abandoned request.

Decomposition:
- Shared constants go in define/ctrl_def.v: LDOP_LW=3'd0, LDOP_LH=3'd1, LDOP_LHU=3'd2, LDOP_LB=3'd3, LDOP_LBU=3'd4, and FSM state codes ST_IDLE/ST_REQ.
- One combinational sub-module, load_ext: inputs op, offset[1:0], word[31:0]; output data[31:0]. It performs lane select plus extension.
- The top level holds the FSM, counter, latches and outputs.

Test Plan:
- LB addr 0x00001003, ack after 1 cycle, rdata 0x80123456 -> wb_data 0xFFFFFF80, wb_valid one pulse at T+2. Same with LBU -> 0x00000080.
- LH addr 0x00001002, rdata 0x8001ABCD -> 0xFFFF8001; LHU -> 0x00008001; LH addr 0x1000 -> 0xFFFFABCD.
- LW addr 0x00001002 -> adel pulse, badvaddr 0x00001002, mem_req never asserts, stall 0.
- LW addr 0x2000 with ack delayed 3 cycles -> mem_req/mem_addr 0x2000 stable 4 cycles, stall high until the wb_valid cycle, wb_data=rdata. A second load accepted in the wb_valid cycle.
- flush asserted in REQ, ack 2 cycles later -> no wb_valid, stall drops after ack, next load serviced normally.
- TIMEOUT=4, no ack -> bus_err after 4 REQ cycles, badvaddr=mem_addr, IDLE. Separately, rst_n low mid-REQ -> all outputs 0 immediately.
